// File: rtl/rvcpu_mem_pkg.sv
// Shared helpers for the memory-side initiators: counter sizing and
// elaboration-time parameter legality checks.
package rvcpu_mem_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The FIFO must be able to absorb every read already launched into the RAM pipeline.
  function automatic bit reader_params_ok(input int read_latency, input int buf_depth);
    return (read_latency >= 1) && (buf_depth >= read_latency + 1);
  endfunction

endpackage

// File: rtl/sdpram_rsp_fifo.sv
// Synchronous ring-buffer FIFO for RAM read responses; any depth >= 1,
// pointers wrap modulo Depth. Synchronous active-low reset on rst.
module sdpram_rsp_fifo
  import rvcpu_mem_pkg::*;
#(
  parameter int Depth = 3,
  parameter int Width = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             head,
  output logic [cnt_width(Depth)-1:0]  count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = cnt_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !do_pop)
      assert (count_q < CntW'(Depth)) else $error("sdpram_rsp_fifo: push into full FIFO");
  end

endmodule

// File: rtl/sdpram_stream_reader.sv
// Read-port initiator for the simple dual-port RAM with a credit-guarded response FIFO.
// Define SDPRAM_READER_BYPASS_EN to let returning data skip an empty FIFO.
module sdpram_stream_reader
  import rvcpu_mem_pkg::*;
#(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32,
  parameter int ReadLatency  = 1,
  parameter int BufDepth     = ReadLatency + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [AddrBusWidth-1:0] req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataBusWidth-1:0] rsp_data,
  output logic                    ram_re,
  output logic [AddrBusWidth-1:0] ram_addr,
  input  logic [DataBusWidth-1:0] ram_rdata,
  output logic                    busy
);

  localparam int CntW = cnt_width(BufDepth);
  localparam int SumW = CntW + 1;

  if (!reader_params_ok(ReadLatency, BufDepth)) begin : g_param_err
    $error("sdpram_stream_reader: need ReadLatency >= 1 and BufDepth >= ReadLatency+1");
  end

  logic [ReadLatency-1:0]  vld_pipe_q, vld_pipe_d;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic [CntW-1:0]         fifo_cnt;
  logic                    started_q;
  logic                    issue, ret, push, pop, fifo_empty, credit_ok;
  logic [DataBusWidth-1:0] fifo_head;

  // Every launched read owns a FIFO slot until its response is consumed.
  assign credit_ok  = (SumW'(inflight_q) + SumW'(fifo_cnt)) < SumW'(BufDepth);
  assign req_ready  = started_q && rst && credit_ok;
  assign issue      = req_valid && req_ready;
  assign ram_re     = issue;
  assign ram_addr   = req_addr;
  assign ret        = vld_pipe_q[ReadLatency-1];
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = rsp_ready && !fifo_empty;
  assign busy       = (inflight_q != '0) || !fifo_empty;

`ifdef SDPRAM_READER_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && ret;
  assign rsp_valid = !fifo_empty || bypass;
  assign rsp_data  = !fifo_empty ? fifo_head : (bypass ? ram_rdata : '0);
  assign push      = ret && !(bypass && rsp_ready);
`else
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? fifo_head : '0;
  assign push      = ret;
`endif

  always_comb begin
    vld_pipe_d = (vld_pipe_q << 1) | ReadLatency'(issue);
    inflight_d = inflight_q + CntW'(issue) - CntW'(ret);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      inflight_q <= '0;
      started_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      inflight_q <= inflight_d;
      started_q  <= 1'b1;
    end
  end

  sdpram_rsp_fifo #(
    .Depth (BufDepth),
    .Width (DataBusWidth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ram_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Self-checking bench for sdpram_stream_reader against a RAM model and a
// transaction-level scoreboard (outstanding reads, visibility time, in-order data).
module tb_sdpram_stream_reader;

  localparam int RL = 2;
  localparam int BD = RL + 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef SDPRAM_READER_BYPASS_EN
  localparam int LAT = RL;
`else
  localparam int LAT = RL + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, rsp_valid, ram_re, busy;
  logic [DW-1:0] rsp_data, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RL];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sdpram_stream_reader #(
    .AddrBusWidth (AW),
    .DataBusWidth (DW),
    .ReadLatency  (RL),
    .BufDepth     (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // RAM read port: fixed latency, garbage on cycles without a read
  always @(posedge clk) begin
    rd_pipe[0] <= ram_re ? mem[ram_addr[7:0]] : {16'hBAD0, 16'($urandom())};
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RL-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: a read accepted in cycle t is visible from t+LAT, in order;
  // a new request is accepted exactly while fewer than BD reads are unconsumed.
  bit            after_rst = 1'b1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    if (!rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_ram_re", ram_re, 0);
      sb.delete();
      after_rst  = 1'b1;
      prev_stall = 1'b0;
    end else begin
      exp_v   = (sb.size() != 0) && (cyc >= sb[0].t + LAT);
      exp_rdy = !after_rst && (sb.size() < BD);
      chk("req_ready", req_ready, exp_rdy);
      chk("ram_re", ram_re, req_valid && exp_rdy);
      if (ram_re) chk("ram_addr", ram_addr, req_addr);
      chk("rsp_valid", rsp_valid, exp_v);
      chk("busy", busy, sb.size() != 0);
      if (after_rst) chk("post_rst_rsp_data", rsp_data, 0);
      if (prev_stall) chk("stall_stable", rsp_data, prev_data);
      if (exp_v) begin
        chk("rsp_data", rsp_data, sb[0].data);
        if (rsp_ready) void'(sb.pop_front());
      end
      if (req_valid && exp_rdy) begin
        sb.push_back('{data: mem[req_addr[7:0]], t: cyc});
        n_acc++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      after_rst  = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            vld;
    logic [7:0]    addr;
    bit            e_valid;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl[20];

  initial begin
    int acc, got, acc0;

    for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? DW'(i * 'h11) : {1'b0, 31'($urandom())};
    for (int j = 0; j < 20; j++) begin
      tbl[j].vld     = (j < 16);
      tbl[j].addr    = 8'(j);
      tbl[j].e_valid = (j >= LAT) && (j < 16 + LAT);
      tbl[j].e_data  = (j >= LAT) ? DW'((j - LAT) * 'h11) : '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("first_cycle_req_ready", req_ready, 0);
    step();
    step();

    // Back-to-back addresses 0..15 with rsp_ready held
    rsp_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      req_valid = tbl[j].vld;
      req_addr  = AW'(tbl[j].addr);
      @(negedge clk);
      chk("b2b_req_ready", req_ready, 1);
      chk("b2b_rsp_valid", rsp_valid, tbl[j].e_valid);
      if (tbl[j].e_valid) chk("b2b_rsp_data", rsp_data, tbl[j].e_data);
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();

    // Fill with consumer stalled: exactly BD accepts, then drain in order
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      req_addr = AW'(32'h40 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      step();
    end
    @(negedge clk);
    chk("fill_accepted", DW'(acc), DW'(BD));
    chk("fill_req_ready_low", req_ready, 0);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("fill_drain_data", rsp_data, mem[8'(32'h40 + got)]);
        got++;
      end
      step();
    end
    chk("fill_drain_count", DW'(got), DW'(BD));
    @(negedge clk);
    chk("fill_req_ready_back", req_ready, 1);
    step();

    // Push and pop together with two entries buffered, then stream across the wrap
    for (int k = 0; k < 26; k++) begin
      req_valid = (k < 2) || (k == 4) || (k == 5) || (k >= 8 && k < 18);
      rsp_ready = (k >= 6);
      req_addr  = AW'(32'h90 + k);
      @(negedge clk);
      if (k == 6) chk("pp_head_a", rsp_data, mem[8'h90]);
      if (k == 7) chk("pp_head_b", rsp_data, mem[8'h91]);
      if (k == 8) chk("pp_head_c", rsp_data, mem[8'h94]);
      step();
    end
    @(negedge clk);
    chk("pp_idle_busy", busy, 0);
    step();

    // Reset with reads in flight and data buffered
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = AW'(32'hC0 + k);
      step();
    end
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready0", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    @(negedge clk);
    chk("mid_rst_req_ready1", req_ready, 1);
    step();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
      step();
    end

    // Random traffic with 50% consumer backpressure
    acc0 = n_acc;
    for (int c = 0; c < 6000 && (n_acc - acc0) < 1000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom_range(0, 255));
      rsp_ready = $urandom_range(0, 1) == 1;
      step();
    end
    chk("rand_accepted", DW'((n_acc - acc0) >= 1000), 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) step();
    chk("rand_drained", DW'(sb.size()), 0);
    @(negedge clk);
    chk("rand_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdpram_stream_reader.md
Name: sdpram_stream_reader

Overview:
- Initiator for the read port of the team's simple dual-port RAM.
- Accepts read requests on a valid/ready stream, drives the RAM's re/addr, and tracks reads in flight through the RAM's fixed ReadLatency pipeline.
- Captures returning data into a small response FIFO and presents it on a valid/ready response stream with full backpressure.
- Sits between fetch/load logic and any sdpram instance; lets a stalling consumer use a fixed-latency RAM without losing data.

Parameters:
- AddrBusWidth, 32, request/RAM address width.
- DataBusWidth, 32, RAM/response data width.
- ReadLatency, 1, must equal the attached RAM's ReadLatency; must be >= 1, elaboration $error otherwise.
- BufDepth, ReadLatency+2, response FIFO entries; must be >= ReadLatency+1, elaboration $error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  AddrBusWidth  read address.
- rsp_valid  out  1  response data present.
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
- rsp_data  out  DataBusWidth  read data, returned in request order.
- ram_re  out  1  to RAM re_b.
- ram_addr  out  AddrBusWidth  to RAM addr_b.
- ram_rdata  in  DataBusWidth  from RAM r_data_b.
- busy  out  1  any read in flight or any FIFO entry valid.

Behaviour:
- Reset (rst==0 at posedge): clears the in-flight shift register, FIFO pointers and count. During reset and the first cycle after it, outputs are req_ready=0, rsp_valid=0, ram_re=0, busy=0, rsp_data=0. ram_addr is don't-care.
- Issue path: ram_re = req_valid && req_ready && rst; ram_addr = req_addr, combinational pass-through. No request register.
- Credit rule: req_ready = (inflight_cnt + fifo_cnt) < BufDepth.
  - Both counts are registered.
  - req_ready never depends combinationally on rsp_ready or req_valid.
- In-flight tracking: ReadLatency-bit shift register vld_pipe. Bit 0 is loaded with the issue handshake each cycle.
  - inflight_cnt = popcount of vld_pipe, or an equivalent up/down counter.
- Return: when the MSB of vld_pipe is set, ram_rdata is valid in that cycle and is pushed into the FIFO at the next posedge.
  - The credit rule guarantees the push never meets a full FIFO. An assertion fires if it does.
- Output: rsp_valid = fifo_cnt != 0; rsp_data = FIFO head. rsp_data holds stable while rsp_valid && !rsp_ready.
- Latency (non-bypass): a request accepted in cycle t gives rsp_valid in cycle t+ReadLatency+1 if the FIFO was empty.
- Throughput: 1 response/cycle is sustained with rsp_ready=1 and BufDepth >= ReadLatency+2.
  - BufDepth = ReadLatency+1 limits throughput to below 1/cycle.
- Simultaneous push and pop: fifo_cnt is unchanged and both pointers advance. Pointers wrap modulo BufDepth; non-power-of-2 depths are supported.
- rsp_ready toggling while rsp_valid=0: no effect.
- Reset mid-operation: in-flight reads and buffered data are discarded. RAM data arriving after reset is ignored because vld_pipe was cleared.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0).

Optional Feature:
- Macro: SDPRAM_READER_BYPASS_EN.
- Defined: when the FIFO is empty and the vld_pipe MSB is set, rsp_valid=1 and rsp_data=ram_rdata combinationally in that cycle.
  - If rsp_ready=1, the entry is consumed without a push. Latency becomes ReadLatency.
  - If rsp_ready=0, the data is pushed as normal.
- Undefined: all responses go through the FIFO. Latency is ReadLatency+1 and there is no combinational path from ram_rdata to rsp_*.

Decomposition:
- Package rvcpu_mem_pkg:
  - cnt_width(depth) function ($clog2(depth+1)).
  - Parameter-check helper for the ReadLatency/BufDepth elaboration errors.
- Sub-module sdpram_rsp_fifo: synchronous ring-buffer FIFO with params Depth and Width.
  - Ports: push, push_data, pop, head, count.
  - Registered count; same reset convention.

Test Plan:
- ReadLatency=1, RAM preloaded mem[i]=i*0x11, rsp_ready=1, addresses 0..15 back-to-back: 16 responses 0x00..0xFF in order, 1/cycle after the first, first response at t+2 (t+1 with bypass), req_ready stays 1.
- ReadLatency=3, BufDepth=5, rsp_ready=0, req_valid held high: exactly 5 requests accepted, then req_ready=0. Release rsp_ready: 5 responses in order, then req_ready returns to 1.
- rsp_ready random 50%, 1000 random addresses, ReadLatency=2: scoreboard shows in-order data matching a RAM model, no drops or duplicates, rsp_data stable while stalled.
- Push and pop in the same cycle with the FIFO at count=2: count stays 2 and pointers wrap correctly across the depth boundary (BufDepth=3).
- Assert rst=0 with 3 reads in flight and 2 buffered, hold 1 cycle: rsp_valid=0, busy=0, req_ready=0 in the first post-reset cycle then 1, and no stale response appears afterwards.
- BufDepth=ReadLatency (illegal): elaboration fails with $error.
